multimode_ff_bank: RTL and testbench
====================================

// Module: multimode_ff_bank
// PURPOSE
//  WIDTH-bit bank of flip-flops, each bit behaving as a D, T, SR or JK flip-flop
//  according to a registered mode. All modes are built on one shared T-flip-flop core.
//  Adds a configurable policy for SR S=R=1, a sticky illegal-input flag and a
//  saturating illegal-event counter. Used as the general storage element in lab datapaths.
// PARAMETERS
//  WIDTH      4     number of flip-flop bits
//  RST_VAL    0     q reset value, WIDTH bits (qbar resets to ~RST_VAL)
//  MODE_RST   2     mode after reset (2 = SR)
//  SR_BOTH    0     SR S=R=1 policy: 0 hold, 1 set, 2 reset, 3 toggle
//  CNT_W      8     width of illegal-event counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-high
//  mode_ld     in   1      load mode_in into mode register
//  mode_in     in   2      00 D, 01 T, 10 SR, 11 JK
//  en          in   1      update enable; 0 = all bits hold
//  a           in   WIDTH  D / T / S / J per bit
//  b           in   WIDTH  R / K per bit (ignored in D, T modes)
//  clr_flag    in   1      clear sticky flag and counter
//  q           out  WIDTH  state
//  qbar        out  WIDTH  always ~q
//  mode        out  2      current registered mode
//  illegal     out  1      sticky: SR-mode S=R=1 seen on any bit with en=1
//  illegal_cnt out  CNT_W  saturating count of cycles with illegal input
// BEHAVIOUR
//  Reset (async, rst=1): q=RST_VAL, qbar=~RST_VAL, mode=MODE_RST, illegal=0, illegal_cnt=0.
//  Mode register: on clk edge with mode_ld=1, mode<=mode_in; new mode governs the NEXT
//   edge (1-cycle latency). The edge that loads the mode updates q using the old mode.
//  Per bit, toggle t computed from registered mode, a, b, q; q<=q^t when en=1:
//   D:  t=a^q.  T: t=a.  JK: t=(a&~q)|(b&q)  (J=K=1 toggles).
//   SR: a&~b -> t=~q; ~a&b -> t=q; ~a&~b -> t=0; a&b -> per SR_BOTH
//       (hold t=0, set t=~q, reset t=q, toggle t=1).
//  en=0: q holds in every mode; no illegal detection.
//  Illegal event: mode==SR & en & |(a&b). On edge: illegal<=1; illegal_cnt+=1,
//   saturating at all-ones (no wrap).
//  clr_flag=1 on an edge: illegal<=0, illegal_cnt<=0; clr_flag has priority over a
//   simultaneous illegal event (that event is dropped).
//  Latency: q, qbar valid one edge after inputs sampled; no combinational path
//   from a/b to q. qbar is ~q at all times, including during reset.
//  rst asserted mid-operation: all state returns to reset values immediately,
//   independent of clk; first edge after deassertion uses mode=MODE_RST.
// STRUCTURE
//  Package ff_bank_pkg: mode encodings (MODE_D/T/SR/JK), SR_BOTH policy encodings,
//   function next_t(mode,a,b,q,policy) returning one bit's toggle.
//  Sub-module t_ff_bank (WIDTH, RST_VAL): clk, rst, en, t[WIDTH] -> q; only holder of q.
//  Top: mode register, t-generation per bit, illegal flag/counter logic.
// TESTING
//  1 Reset: WIDTH=4, RST_VAL=4'b0101, rst=1 -> q=0101, qbar=1010, mode=10, illegal=0.
//  2 SR mode: a=0001,b=0000 -> q=0001; a=0000,b=0001 -> q=0000; a=b=0000 -> hold.
//  3 SR a=b=0001 for SR_BOTH=0,1,2,3 from q=0000 -> 0000/0001/0000/0001;
//    illegal=1, illegal_cnt=1; repeat 300 cycles (CNT_W=8) -> cnt stays 255.
//  4 Mode switch: mode_ld=1, mode_in=01 with a=1111 -> that edge acts as SR,
//    next edge toggles q=~q; mode_in=00, a=1010 -> q=1010 one edge after mode active.
//  5 JK a=b=1111 toggles every edge; en=0 for 3 edges -> q frozen.
//  6 clr_flag with simultaneous illegal input -> illegal=0, cnt=0; rst pulse
//    between edges mid-JK-toggle -> q=RST_VAL immediately, mode=10.

Source files
------------

// File: rtl/ff_bank_pkg.sv
// Shared encodings and the per-bit toggle function for the multimode flip-flop bank.
// Every mode is reduced to a T input for a common T-flip-flop core.
package ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        SRB_HOLD   = 2'd0,
        SRB_SET    = 2'd1,
        SRB_RESET  = 2'd2,
        SRB_TOGGLE = 2'd3
    } sr_both_t;

    function automatic logic next_t(input mode_t mode, input logic a, input logic b,
                                    input logic q, input sr_both_t policy);
        logic t;
        t = 1'b0;
        case (mode)
            MODE_D:  t = a ^ q;
            MODE_T:  t = a;
            MODE_JK: t = (a & ~q) | (b & q);
            MODE_SR: begin
                case ({a, b})
                    2'b10:   t = ~q;
                    2'b01:   t = q;
                    2'b00:   t = 1'b0;
                    default: begin
                        case (policy)
                            SRB_HOLD:  t = 1'b0;
                            SRB_SET:   t = ~q;
                            SRB_RESET: t = q;
                            default:   t = 1'b1;
                        endcase
                    end
                endcase
            end
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/t_ff_bank.sv
// Bank of T flip-flops; the only storage for the bank state q.
module t_ff_bank #(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// Multimode D/T/SR/JK flip-flop bank: registered mode, per-bit toggle generation,
// sticky SR S=R=1 flag and a saturating illegal-event counter.
module multimode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int unsigned       WIDTH    = 4,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0,
    parameter logic [1:0]        MODE_RST = 2'd2,
    parameter logic [1:0]        SR_BOTH  = 2'd0,
    parameter int unsigned       CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_ld,
    input  logic [1:0]       mode_in,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [1:0]       mode,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    mode_t            mode_r;
    logic [WIDTH-1:0] t;
    logic             illegal_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= mode_t'(MODE_RST);
        end else if (mode_ld) begin
            mode_r <= mode_t'(mode_in);
        end
    end

    // Toggles come from the registered mode, so a mode load only takes effect next edge.
    always_comb begin
        t = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t[i] = next_t(mode_r, a[i], b[i], q[i], sr_both_t'(SR_BOTH));
        end
    end

    t_ff_bank #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .t   (t),
        .q   (q)
    );

    assign qbar = ~q;
    assign mode = mode_r;

    assign illegal_evt = (mode_r == MODE_SR) && en && (|(a & b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else if (clr_flag) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else if (illegal_evt) begin
            illegal <= 1'b1;
            if (illegal_cnt != '1) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed self-checking bench: four instances differing only in SR S=R=1 policy.
module tb_multimode_ff_bank;

    logic       clk, rst, mode_ld, en, clr_flag;
    logic [1:0] mode_in;
    logic [3:0] a, b;
    logic [3:0] q_a    [4];
    logic [3:0] qb_a   [4];
    logic [1:0] mode_a [4];
    logic       ill_a  [4];
    logic [7:0] cnt_a  [4];
    int total = 0;
    int bad   = 0;

    multimode_ff_bank #(.WIDTH(4), .RST_VAL(4'b0101), .MODE_RST(2'd2), .SR_BOTH(2'd0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en), .a(a), .b(b),
        .clr_flag(clr_flag), .q(q_a[0]), .qbar(qb_a[0]), .mode(mode_a[0]), .illegal(ill_a[0]),
        .illegal_cnt(cnt_a[0]));
    multimode_ff_bank #(.WIDTH(4), .RST_VAL(4'b0101), .MODE_RST(2'd2), .SR_BOTH(2'd1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en), .a(a), .b(b),
        .clr_flag(clr_flag), .q(q_a[1]), .qbar(qb_a[1]), .mode(mode_a[1]), .illegal(ill_a[1]),
        .illegal_cnt(cnt_a[1]));
    multimode_ff_bank #(.WIDTH(4), .RST_VAL(4'b0101), .MODE_RST(2'd2), .SR_BOTH(2'd2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en), .a(a), .b(b),
        .clr_flag(clr_flag), .q(q_a[2]), .qbar(qb_a[2]), .mode(mode_a[2]), .illegal(ill_a[2]),
        .illegal_cnt(cnt_a[2]));
    multimode_ff_bank #(.WIDTH(4), .RST_VAL(4'b0101), .MODE_RST(2'd2), .SR_BOTH(2'd3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en), .a(a), .b(b),
        .clr_flag(clr_flag), .q(q_a[3]), .qbar(qb_a[3]), .mode(mode_a[3]), .illegal(ill_a[3]),
        .illegal_cnt(cnt_a[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_ld = 1'b0; mode_in = 2'b00; en = 1'b0; clr_flag = 1'b0;
        a = 4'b0000; b = 4'b0000;
        #2;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_a[i] !== 4'b0101 || qb_a[i] !== 4'b1010) begin
                bad++; $display("FAIL reset_q dut%0d q=%b qbar=%b exp q=0101 qbar=1010", i, q_a[i], qb_a[i]);
            end
            total++;
            if (mode_a[i] !== 2'b10 || ill_a[i] !== 1'b0 || cnt_a[i] !== 8'd0) begin
                bad++; $display("FAIL reset_state dut%0d mode=%b ill=%b cnt=%0d exp 10/0/0", i, mode_a[i], ill_a[i], cnt_a[i]);
            end
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_sr();
        en = 1'b1; a = 4'b0000; b = 4'b1111;
        step();
        total++;
        if (q_a[0] !== 4'b0000) begin bad++; $display("FAIL sr_reset_all q=%b exp=0000", q_a[0]); end
        a = 4'b0001; b = 4'b0000;
        step();
        total++;
        if (q_a[0] !== 4'b0001) begin bad++; $display("FAIL sr_set q=%b exp=0001", q_a[0]); end
        a = 4'b0000; b = 4'b0001;
        step();
        total++;
        if (q_a[0] !== 4'b0000) begin bad++; $display("FAIL sr_reset q=%b exp=0000", q_a[0]); end
        a = 4'b0000; b = 4'b0000;
        step();
        total++;
        if (q_a[0] !== 4'b0000 || q_a[3] !== 4'b0000) begin
            bad++; $display("FAIL sr_hold q0=%b q3=%b exp=0000", q_a[0], q_a[3]);
        end
        total++;
        if (ill_a[0] !== 1'b0 || cnt_a[0] !== 8'd0) begin
            bad++; $display("FAIL sr_no_illegal ill=%b cnt=%0d exp 0/0", ill_a[0], cnt_a[0]);
        end
    endtask

    task automatic test_sr_both();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'b0000; exp_q[1] = 4'b0001; exp_q[2] = 4'b0000; exp_q[3] = 4'b0001;
        a = 4'b0001; b = 4'b0001;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_a[i] !== exp_q[i]) begin bad++; $display("FAIL sr_both_q dut%0d q=%b exp=%b", i, q_a[i], exp_q[i]); end
            total++;
            if (ill_a[i] !== 1'b1 || cnt_a[i] !== 8'd1) begin
                bad++; $display("FAIL sr_both_flag dut%0d ill=%b cnt=%0d exp 1/1", i, ill_a[i], cnt_a[i]);
            end
        end
        for (int k = 2; k <= 301; k++) begin
            step();
            if (k == 254 || k == 255 || k == 256) begin
                total++;
                if (cnt_a[0] !== ((k > 255) ? 8'd255 : 8'(k))) begin
                    bad++; $display("FAIL cnt_sat_edge k=%0d cnt=%0d exp=%0d", k, cnt_a[0], (k > 255) ? 255 : k);
                end
            end
        end
        total++;
        if (cnt_a[0] !== 8'd255 || cnt_a[3] !== 8'd255 || ill_a[0] !== 1'b1) begin
            bad++; $display("FAIL cnt_sat cnt0=%0d cnt3=%0d ill=%b exp 255/255/1", cnt_a[0], cnt_a[3], ill_a[0]);
        end
        total++;
        if (q_a[3] !== 4'b0001 || q_a[2] !== 4'b0000) begin
            bad++; $display("FAIL sr_both_long q3=%b q2=%b exp 0001/0000", q_a[3], q_a[2]);
        end
        en = 1'b0; clr_flag = 1'b1;
        step();
        clr_flag = 1'b0;
        total++;
        if (ill_a[0] !== 1'b0 || cnt_a[0] !== 8'd0 || q_a[0] !== 4'b0000) begin
            bad++; $display("FAIL clr ill=%b cnt=%0d q=%b exp 0/0/0000", ill_a[0], cnt_a[0], q_a[0]);
        end
    endtask

    task automatic test_mode_switch();
        en = 1'b1; a = 4'b1111; b = 4'b0000;
        step();
        total++;
        if (q_a[0] !== 4'b1111) begin bad++; $display("FAIL ms_pre q=%b exp=1111", q_a[0]); end
        mode_ld = 1'b1; mode_in = 2'b01;
        step();
        total++;
        if (q_a[0] !== 4'b1111 || mode_a[0] !== 2'b01) begin
            bad++; $display("FAIL ms_load_edge_sr q=%b mode=%b exp 1111/01", q_a[0], mode_a[0]);
        end
        mode_ld = 1'b0; b = 4'b1111;
        step();
        total++;
        if (q_a[0] !== 4'b0000) begin bad++; $display("FAIL ms_t_toggle q=%b exp=0000", q_a[0]); end
        step();
        total++;
        if (q_a[0] !== 4'b1111) begin bad++; $display("FAIL ms_t_toggle2 q=%b exp=1111", q_a[0]); end
        mode_ld = 1'b1; mode_in = 2'b00; a = 4'b1010;
        step();
        total++;
        if (q_a[0] !== 4'b0101 || mode_a[0] !== 2'b00) begin
            bad++; $display("FAIL ms_load_edge_t q=%b mode=%b exp 0101/00", q_a[0], mode_a[0]);
        end
        mode_ld = 1'b0;
        step();
        total++;
        if (q_a[0] !== 4'b1010) begin bad++; $display("FAIL ms_d q=%b exp=1010", q_a[0]); end
        a = 4'b0011;
        step();
        total++;
        if (q_a[0] !== 4'b0011 || qb_a[0] !== 4'b1100 || ill_a[0] !== 1'b0) begin
            bad++; $display("FAIL ms_d2 q=%b qbar=%b ill=%b exp 0011/1100/0", q_a[0], qb_a[0], ill_a[0]);
        end
    endtask

    task automatic test_jk();
        mode_ld = 1'b1; mode_in = 2'b11; a = 4'b0011; b = 4'b0000;
        step();
        mode_ld = 1'b0;
        total++;
        if (q_a[0] !== 4'b0011 || mode_a[0] !== 2'b11) begin
            bad++; $display("FAIL jk_load q=%b mode=%b exp 0011/11", q_a[0], mode_a[0]);
        end
        a = 4'b1111; b = 4'b1111;
        step();
        total++;
        if (q_a[0] !== 4'b1100) begin bad++; $display("FAIL jk_toggle1 q=%b exp=1100", q_a[0]); end
        step();
        total++;
        if (q_a[0] !== 4'b0011) begin bad++; $display("FAIL jk_toggle2 q=%b exp=0011", q_a[0]); end
        a = 4'b0100; b = 4'b0001;
        step();
        total++;
        if (q_a[0] !== 4'b0110) begin bad++; $display("FAIL jk_set_reset q=%b exp=0110", q_a[0]); end
        en = 1'b0; a = 4'b1111; b = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (q_a[0] !== 4'b0110) begin bad++; $display("FAIL jk_en_hold k=%0d q=%b exp=0110", k, q_a[0]); end
        end
    endtask

    task automatic test_clr_priority();
        en = 1'b1; mode_ld = 1'b1; mode_in = 2'b10;
        step();
        mode_ld = 1'b0;
        total++;
        if (q_a[0] !== 4'b1001 || mode_a[0] !== 2'b10 || ill_a[0] !== 1'b0) begin
            bad++; $display("FAIL cp_to_sr q=%b mode=%b ill=%b exp 1001/10/0", q_a[0], mode_a[0], ill_a[0]);
        end
        a = 4'b0001; b = 4'b0001;
        step();
        total++;
        if (q_a[0] !== 4'b1001 || ill_a[0] !== 1'b1 || cnt_a[0] !== 8'd1) begin
            bad++; $display("FAIL cp_illegal q=%b ill=%b cnt=%0d exp 1001/1/1", q_a[0], ill_a[0], cnt_a[0]);
        end
        en = 1'b0; a = 4'b1111; b = 4'b1111;
        step();
        total++;
        if (cnt_a[0] !== 8'd1 || q_a[1] !== 4'b1001) begin
            bad++; $display("FAIL cp_en0_no_illegal cnt=%0d q1=%b exp 1/1001", cnt_a[0], q_a[1]);
        end
        en = 1'b1; clr_flag = 1'b1; a = 4'b0001; b = 4'b0001;
        step();
        clr_flag = 1'b0;
        total++;
        if (ill_a[0] !== 1'b0 || cnt_a[0] !== 8'd0 || q_a[0] !== 4'b1001) begin
            bad++; $display("FAIL cp_clr_priority ill=%b cnt=%0d q=%b exp 0/0/1001", ill_a[0], cnt_a[0], q_a[0]);
        end
    endtask

    task automatic test_async_reset();
        mode_ld = 1'b1; mode_in = 2'b11; a = 4'b0000; b = 4'b0000;
        step();
        mode_ld = 1'b0; a = 4'b1111; b = 4'b1111;
        step();
        total++;
        if (q_a[0] !== 4'b0110 || mode_a[0] !== 2'b11) begin
            bad++; $display("FAIL ar_pre q=%b mode=%b exp 0110/11", q_a[0], mode_a[0]);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (q_a[0] !== 4'b0101 || qb_a[0] !== 4'b1010 || mode_a[0] !== 2'b10) begin
            bad++; $display("FAIL ar_immediate q=%b qbar=%b mode=%b exp 0101/1010/10", q_a[0], qb_a[0], mode_a[0]);
        end
        rst = 1'b0;
        step();
        total++;
        if (q_a[0] !== 4'b0101 || q_a[1] !== 4'b1111 || ill_a[0] !== 1'b1 || cnt_a[0] !== 8'd1) begin
            bad++; $display("FAIL ar_first_edge_sr q0=%b q1=%b ill=%b cnt=%0d exp 0101/1111/1/1",
                            q_a[0], q_a[1], ill_a[0], cnt_a[0]);
        end
    endtask

    initial begin
        test_reset();
        test_sr();
        test_sr_both();
        test_mode_switch();
        test_jk();
        test_clr_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
